// File: rtl/serial_rx_seq.sv
// serial_rx_seq: oversampling serial frame receiver that sequences a downstream
// serial-in shift register (sync-clear, shift-enable, serial bit) and flags
// frame completion or framing errors.
//
// Frame format: start bit (0), DATA_BITS data bits MSB first, stop bit (1).
// Optional even-parity bit between data and stop when SERIAL_RX_PARITY_EN is
// defined; with the macro undefined there is no parity state or logic.
//
// Constraints: CLKS_PER_BIT >= 4, DATA_BITS >= 2.
module serial_rx_seq #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_sclr,
  output logic o_en,
  output logic o_bit,
  output logic o_done,
  output logic o_frame_err,
  output logic o_busy
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW   = $clog2(DATA_BITS + 1);

  // Start-bit confirmation point (middle of the start bit).
  localparam logic [CW-1:0] CntHalfM1 = CW'(HALF - 1);
  // Mid-bit sample point once aligned to the middle of the start bit.
  localparam logic [CW-1:0] CntLast   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BitLast   = BW'(DATA_BITS - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;

  // Two-flop synchroniser, reset to the idle-high line level.
  logic rx_meta_q;
  logic rx_s_q;

  logic sclr_q, sclr_d;
  logic en_q, en_d;
  logic bit_q, bit_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic busy_q, busy_d;

`ifdef SERIAL_RX_PARITY_EN
  logic par_q, par_d;    // running XOR of received data bits
  logic perr_q, perr_d;  // sticky parity mismatch for the current frame
`endif

  // Synchronise the asynchronous serial line into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      sclr_q    <= 1'b0;
      en_q      <= 1'b0;
      bit_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclr_q    <= sclr_d;
      en_q      <= en_d;
      bit_q     <= bit_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
`ifdef SERIAL_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sclr_d    = 1'b0;
    en_d      = 1'b0;
    bit_d     = bit_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = perr_q;
`endif

    unique case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        if (!rx_s_q) begin
          state_d = StStart;
`ifdef SERIAL_RX_PARITY_EN
          par_d   = 1'b0;
          perr_d  = 1'b0;
`endif
        end
      end

      StStart: begin
        if (clk_cnt_q == CntHalfM1) begin
          clk_cnt_d = '0;
          if (!rx_s_q) begin
            // Start bit still low at its middle: real frame.
            sclr_d    = 1'b1;
            bit_cnt_d = '0;
            state_d   = StData;
          end else begin
            // Line went back high: treat as a glitch.
            state_d = StIdle;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StData: begin
        if (clk_cnt_q == CntLast) begin
          clk_cnt_d = '0;
          en_d      = 1'b1;
          bit_d     = rx_s_q;
          bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef SERIAL_RX_PARITY_EN
          par_d     = par_q ^ rx_s_q;
`endif
          if (bit_cnt_q == BitLast) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

`ifdef SERIAL_RX_PARITY_EN
      StParity: begin
        if (clk_cnt_q == CntLast) begin
          clk_cnt_d = '0;
          // Even parity: data XOR parity bit must be 0.
          if (par_q ^ rx_s_q) begin
            perr_d = 1'b1;
          end
          state_d = StStop;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`endif

      StStop: begin
        if (clk_cnt_q == CntLast) begin
          clk_cnt_d = '0;
`ifdef SERIAL_RX_PARITY_EN
          if (rx_s_q && !perr_q) begin
`else
          if (rx_s_q) begin
`endif
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          // Leave at mid-stop so a back-to-back start edge is not missed.
          state_d = StIdle;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = StIdle;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase

    // Busy tracks the registered state exactly.
    busy_d = (state_d != StIdle);
  end

  assign o_sclr      = sclr_q;
  assign o_en        = en_q;
  assign o_bit       = bit_q;
  assign o_done      = done_q;
  assign o_frame_err = err_q;
  assign o_busy      = busy_q;

endmodule

// File: doc/serial_rx_seq.md
Name: serial_rx_seq

Overview:
- Upstream sequencer for the serial-in shift register.
- Oversamples a raw asynchronous serial line and detects frames (start bit, DATA_BITS data bits MSB first, stop bit).
- Drives the shift register's sync-clear, shift-enable and serial-bit inputs, then flags frame completion.
- Frame data lands in the downstream register with the first-received bit at the MSB, so the downstream COUNT must equal DATA_BITS.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be at least 4. HALF = CLKS_PER_BIT/2, integer division.
- DATA_BITS, 8: data bits per frame; must be at least 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- i_rx  in  1  raw serial line, idle high, asynchronous to clk
- o_sclr  out  1  one-cycle pulse that clears the downstream shift register at start-bit confirmation
- o_en  out  1  one-cycle shift-enable pulse per data bit
- o_bit  out  1  sampled data bit; valid while o_en=1
- o_done  out  1  one-cycle pulse; frame good, downstream data is complete
- o_frame_err  out  1  one-cycle pulse; bad stop bit (or parity, see Optional Feature)
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous):
  - State = IDLE, bit counter = 0, clock counter = 0.
  - Two-flop synchroniser stages = 1.
  - All outputs = 0.
- Input path: i_rx passes through the 2-flop synchroniser to give rx_s. All decisions below use rx_s only.
- All outputs are registered. Pulses are exactly 1 cycle wide.
- IDLE:
  - Clock counter held at 0.
  - rx_s=0 -> go to START with clock counter = 0.
- START:
  - Clock counter increments each cycle.
  - When the counter reaches HALF-1, sample rx_s:
    - 0 -> assert o_sclr for one cycle, go to DATA, clock counter = 0, bit counter = 0.
    - 1 -> glitch: go to IDLE, no outputs.
- DATA:
  - Clock counter counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - At CLKS_PER_BIT-1 (mid-bit): o_en=1 for one cycle, o_bit=rx_s, bit counter increments.
  - After the DATA_BITS-th sample, go to STOP with clock counter = 0.
- STOP:
  - At CLKS_PER_BIT-1, sample rx_s:
    - 1 -> o_done pulse.
    - 0 -> o_frame_err pulse.
  - In both cases go to IDLE on the same edge.
  - After o_frame_err, IDLE still waits for rx_s=0. A held-low line re-enters START at once (break condition gives repeated errors).
- Timing:
  - o_sclr precedes the first o_en by CLKS_PER_BIT cycles.
  - Successive o_en pulses are exactly CLKS_PER_BIT cycles apart.
  - o_done follows the last o_en by CLKS_PER_BIT cycles (exactly 2*CLKS_PER_BIT with the Optional Feature), so downstream o_data is stable when o_done=1.
  - o_done and o_frame_err are never both 1.
  - o_sclr and o_en are never both 1.
- Back-to-back frames: returning to IDLE at mid-stop allows the next start edge to be caught without a gap cycle.
- Mid-frame i_rx glitches are not filtered; each bit is sampled once at mid-bit.
- Reset mid-frame: all state is abandoned immediately and no pulse is emitted. The downstream register is not cleared by this block until the next o_sclr.
- Counter width: clog2(CLKS_PER_BIT), minimum 1. Bit counter width: clog2(DATA_BITS+1).

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN
- Defined:
  - Extra PARITY state between DATA and STOP, one bit period long, sampled at CLKS_PER_BIT-1.
  - Running XOR of the data bits; even parity required (data XOR parity bit = 0).
  - The parity bit is not shifted downstream (no o_en).
  - Parity mismatch latches an error flag. At the STOP sample, the flag forces o_frame_err instead of o_done, even if stop=1.
  - The flag clears on entry to START.
- Undefined: no PARITY state, no parity logic; the frame goes DATA -> STOP directly.

Test Plan:
- Reset then i_rx=1 for 100 cycles, defaults CLKS_PER_BIT=16, DATA_BITS=8 -> all outputs 0, o_busy=0.
- Send 0xA5 MSB first (bits 1,0,1,0,0,1,0,1), stop=1, into a downstream 8-bit shift register -> one o_sclr, 8 o_en pulses 16 cycles apart carrying o_bit 1,0,1,0,0,1,0,1, one o_done 16 cycles after the last o_en, downstream o_data=0xA5, no o_frame_err.
- i_rx low for 5 cycles, then high -> START aborts at the HALF-1 check, no o_sclr/o_en/o_done, back to IDLE, o_busy falls.
- Frame 0x3C with stop bit=0 -> 8 o_en, o_frame_err pulse, no o_done. Then a valid frame 0xC3 -> o_done, downstream o_data=0xC3.
- Back-to-back 0x3C, 0xC3 with no idle gap -> two o_done pulses, the second catches 0xC3 correctly. Assert rst after the 4th o_en of a third frame -> outputs 0 immediately, no o_done.
- Parity (with SERIAL_RX_PARITY_EN): 0xA5 with parity 0 -> o_done. 0xA5 with parity 1 -> o_frame_err, no o_done. 8 o_en pulses in both cases.
